// File: rtl/round_key_store_if.sv
// Key-schedule write port and round-datapath read port of round_key_store.
// Writes are fire-and-forget strobes; a read request always gets rd_valid or rd_err on the next cycle.
interface round_key_store_if #(
    parameter int AW = 4,
    parameter int KW = 128
);
    // Key-schedule side: no backpressure, every key_w_e cycle is accepted.
    logic          key_w_e;
    logic [AW-1:0] key_w_addr;
    logic [KW-1:0] key_w_data;
    logic          key_done;
    logic [AW-1:0] rounds_total;
    logic          decrypt;

    // Read side
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [KW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_err;

    // Status and debug
    logic          keys_ready;
    logic          busy;
    logic [1:0]    dbg_state;

    modport master (
        output key_w_e, key_w_addr, key_w_data, key_done, rounds_total, decrypt,
        output rd_en, rd_addr,
        input  rd_data, rd_valid, rd_err, keys_ready, busy, dbg_state
    );

    modport slave (
        input  key_w_e, key_w_addr, key_w_data, key_done, rounds_total, decrypt,
        input  rd_en, rd_addr,
        output rd_data, rd_valid, rd_err, keys_ready, busy, dbg_state
    );
endinterface

// File: rtl/round_key_store.sv
// Round-key store: captures key-schedule output, serves 1-cycle reads gated by keys_ready.
// Define AES_KEY_INV_MIX_EN to add the in-place InvMixColumns pass for decryption keys.
module round_key_store #(
    parameter int DEPTH = 15
) (
    input  logic             clk,
    input  logic             reset,
    round_key_store_if.slave bus
);
    localparam int AW = 4;
    localparam int KW = 128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
`ifdef AES_KEY_INV_MIX_EN
        S_XFORM = 2'd2,
`endif
        S_READY = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rt_q, rt_d;
    logic [KW-1:0] mem [DEPTH];
    logic [KW-1:0] rd_data_q;
    logic          rd_valid_q;
    logic          rd_err_q;
    logic          keys_ready_q;
    logic          busy_q;

    logic          first_wr;
    logic          done_fire;
    logic          wr_in_range;
    logic          rd_ok;

`ifdef AES_KEY_INV_MIX_EN
    logic          dec_q, dec_d;
    logic [AW-1:0] xf_addr_q, xf_addr_d;
    logic [KW-1:0] xf_cur;
    logic [KW-1:0] xf_result;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One InvMixColumns column: rows {0e 0b 0d 09} rotated right per output byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign xf_cur = mem[xf_addr_q];

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign xf_result[127-32*c -: 32] = inv_mix_col(xf_cur[127-32*c -: 32]);
    end
`else
    logic unused_decrypt;
    assign unused_decrypt = bus.decrypt;
`endif

    assign wr_in_range = int'(bus.key_w_addr) < DEPTH;

    // A same-cycle write drops READY, so the read must be refused too.
    assign rd_ok = bus.rd_en && keys_ready_q && !bus.key_w_e &&
                   (bus.rd_addr <= rt_q) && (int'(bus.rd_addr) < DEPTH);

    always_comb begin
        state_d   = state_q;
        rt_d      = rt_q;
        first_wr  = bus.key_w_e && (state_q != S_LOAD);
        done_fire = bus.key_done && (bus.key_w_e || state_q == S_LOAD);
`ifdef AES_KEY_INV_MIX_EN
        dec_d     = dec_q;
        xf_addr_d = 4'd1;
        if (state_q == S_XFORM && !bus.key_w_e) begin
            if (xf_addr_q >= rt_q - 4'd1) begin
                state_d = S_READY;
            end else begin
                xf_addr_d = xf_addr_q + 4'd1;
            end
        end
        if (first_wr) begin
            dec_d = bus.decrypt;
        end
`endif
        if (first_wr) begin
            rt_d = bus.rounds_total;
        end
        if (bus.key_w_e) begin
            state_d = S_LOAD;
        end
        // Done may ride on the final write; that write is stored first.
        if (done_fire) begin
`ifdef AES_KEY_INV_MIX_EN
            state_d = (dec_d && rt_d >= 4'd2) ? S_XFORM : S_READY;
`else
            state_d = S_READY;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rt_q         <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            keys_ready_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef AES_KEY_INV_MIX_EN
            dec_q        <= 1'b0;
            xf_addr_q    <= 4'd1;
`endif
        end else begin
            state_q      <= state_d;
            rt_q         <= rt_d;
            rd_valid_q   <= rd_ok;
            rd_err_q     <= bus.rd_en && !rd_ok;
            keys_ready_q <= (state_d == S_READY);
`ifdef AES_KEY_INV_MIX_EN
            busy_q       <= (state_d == S_LOAD) || (state_d == S_XFORM);
            dec_q        <= dec_d;
            xf_addr_q    <= xf_addr_d;
`else
            busy_q       <= (state_d == S_LOAD);
`endif
            if (rd_ok) begin
                rd_data_q <= mem[bus.rd_addr];
            end
        end
    end

    // Storage is not reset; keys_ready guards every read of stale contents.
    always_ff @(posedge clk) begin
        if (bus.key_w_e) begin
            if (wr_in_range) begin
                mem[bus.key_w_addr] <= bus.key_w_data;
            end
        end
`ifdef AES_KEY_INV_MIX_EN
        else if (state_q == S_XFORM && int'(xf_addr_q) < DEPTH) begin
            mem[xf_addr_q] <= xf_result;
        end
`endif
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.keys_ready = keys_ready_q;
    assign bus.busy       = busy_q;
    assign bus.dbg_state  = state_q;
endmodule
